// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: builds one scanline during horizontal blanking by
// walking the sprite table from the lowest priority (highest index) to the
// highest priority (index 0). Each sprite row that covers the line is read
// from the shared sprite ROM, and its opaque pixels go into the line buffer.
//
// Ports:
//   Clk, Reset_n        clock and asynchronous active-low reset
//   line_start, next_y  start pulse and the scanline to build
//   spr_en/spr_x/spr_y  per-sprite enable, left column and top row (10b each)
//   rom_addr, rom_data  sprite ROM port (the ROM registers the address)
//   lb_we/addr/data     line-buffer write port
//   busy, done, overrun scan status
module sprite_line_scheduler #(
  parameter int unsigned NUM_SPRITES = 4,
  parameter int unsigned SPR_W       = 55,
  parameter int unsigned SPR_H       = 41,
  parameter int unsigned ROM_ADDR_W  = 12,
  parameter int unsigned PIX_W       = 3,
  parameter int unsigned TRANSPARENT = 7,
  parameter int unsigned LINE_W      = 640
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      line_start,
  input  logic [9:0]                next_y,
  input  logic [NUM_SPRITES-1:0]    spr_en,
  input  logic [10*NUM_SPRITES-1:0] spr_x,
  input  logic [10*NUM_SPRITES-1:0] spr_y,
  output logic [ROM_ADDR_W-1:0]     rom_addr,
  input  logic [PIX_W-1:0]          rom_data,
  output logic                      lb_we,
  output logic [9:0]                lb_addr,
  output logic [PIX_W-1:0]          lb_data,
  output logic                      busy,
  output logic                      done,
  output logic                      overrun
);

  localparam int unsigned COORD_W = 10;
  localparam int unsigned EXT_W   = COORD_W + 1;
  localparam int unsigned IDX_W   = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int unsigned COL_W   = $clog2(SPR_W);
  localparam int unsigned ROW_W   = $clog2(SPR_H);

  typedef enum logic [2:0] {IDLE, CHECK, FETCH, DRAIN, FINISH} state_t;

  state_t                      state;
  logic [IDX_W-1:0]            idx;
  logic [COORD_W-1:0]          y_q;
  logic [NUM_SPRITES-1:0]      en_q;
  logic [10*NUM_SPRITES-1:0]   x_q;
  logic [10*NUM_SPRITES-1:0]   sy_q;
  logic [ROW_W-1:0]            row;
  logic [COL_W-1:0]            col;

  // Screen column of the address on rom_addr, then of the data on rom_data.
  logic                        a_vld;
  logic [EXT_W-1:0]            a_col;
  logic                        d_vld;
  logic [EXT_W-1:0]            d_col;

  logic [COORD_W-1:0]          cur_sx;
  logic [COORD_W-1:0]          cur_sy;
  logic [EXT_W-1:0]            y_ext;
  logic [EXT_W-1:0]            sy_ext;
  logic                        hit;
  logic [ROM_ADDR_W-1:0]       fetch_addr;
  logic [EXT_W-1:0]            fetch_col;
  logic                        accept;

  // Per-sprite hit test and fetch address, all in 11 bits so nothing wraps.
  always_comb begin
    cur_sx     = x_q[COORD_W*idx +: COORD_W];
    cur_sy     = sy_q[COORD_W*idx +: COORD_W];
    y_ext      = {1'b0, y_q};
    sy_ext     = {1'b0, cur_sy};
    hit        = en_q[idx] && (y_ext >= sy_ext) && (y_ext < sy_ext + EXT_W'(SPR_H));
    fetch_addr = ROM_ADDR_W'(row) * ROM_ADDR_W'(SPR_W) + ROM_ADDR_W'(col);
    fetch_col  = {1'b0, cur_sx} + EXT_W'(col);
    // A start in the FINISH cycle chains straight into the next scan.
    accept     = line_start && ((state == IDLE) || (state == FINISH));
  end

  // Scan FSM, ROM address issue and line-buffer write pipeline.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      idx      <= '0;
      y_q      <= '0;
      en_q     <= '0;
      x_q      <= '0;
      sy_q     <= '0;
      row      <= '0;
      col      <= '0;
      a_vld    <= 1'b0;
      a_col    <= '0;
      d_vld    <= 1'b0;
      d_col    <= '0;
      rom_addr <= '0;
      lb_we    <= 1'b0;
      lb_addr  <= '0;
      lb_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      done    <= 1'b0;
      overrun <= 1'b0;
      a_vld   <= 1'b0;

      // ROM data arrives one cycle after its address; columns past the
      // visible line are dropped rather than wrapped.
      d_vld <= a_vld;
      d_col <= a_col;
      lb_we <= d_vld && (rom_data != PIX_W'(TRANSPARENT)) && (d_col < EXT_W'(LINE_W));
      if (d_vld) begin
        lb_addr <= d_col[COORD_W-1:0];
        lb_data <= rom_data;
      end

      case (state)
        IDLE: ;
        CHECK: begin
          if (hit) begin
            row   <= ROW_W'(y_ext - sy_ext);
            col   <= '0;
            state <= FETCH;
          end else if (idx == '0) begin
            state <= FINISH;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        FETCH: begin
          rom_addr <= fetch_addr;
          a_vld    <= 1'b1;
          a_col    <= fetch_col;
          if (col == COL_W'(SPR_W - 1)) state <= DRAIN;
          else                          col   <= col + COL_W'(1);
        end
        DRAIN: begin
          if (idx == '0) begin
            state <= FINISH;
          end else begin
            idx   <= idx - IDX_W'(1);
            state <= CHECK;
          end
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        y_q   <= next_y;
        en_q  <= spr_en;
        x_q   <= spr_x;
        sy_q  <= spr_y;
        idx   <= IDX_W'(NUM_SPRITES - 1);
        busy  <= 1'b1;
        state <= CHECK;
      end

      if (line_start && ((state == CHECK) || (state == FETCH) || (state == DRAIN))) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
